// File: rtl/mdu_multicycle_if.sv
// Request/response bundle between execute-stage control and the multiply/divide unit.
// Control drives the request side; the MDU drives status and the HI/LO view.
interface mdu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             MDU_Start;
  logic [2:0]       MDU_Op;
  logic [WIDTH-1:0] MDU_A;
  logic [WIDTH-1:0] MDU_B;
  logic             MDU_Busy;
  logic             MDU_Done;
  logic [WIDTH-1:0] MDU_HI;
  logic [WIDTH-1:0] MDU_LO;

  modport master (
    output MDU_Start, MDU_Op, MDU_A, MDU_B,
    input  MDU_Busy, MDU_Done, MDU_HI, MDU_LO
  );

  modport slave (
    input  MDU_Start, MDU_Op, MDU_A, MDU_B,
    output MDU_Busy, MDU_Done, MDU_HI, MDU_LO
  );
endinterface

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at the start
// edge and held until the configured latency elapses, then committed in one cycle.
module mdu_multicycle #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset,
  mdu_multicycle_if.slave bus
);
  localparam int unsigned MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [2*WIDTH-1:0] r_pend;
  logic [2*WIDTH-1:0] w_res;
  logic               w_load, w_commit, w_md_req, w_mt_hi, w_mt_lo;

  // Returns {HI, LO}; sign extension into 2*WIDTH bits gives the signed product.
  function automatic logic [2*WIDTH-1:0] mul_hilo(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic [2*WIDTH-1:0] ea, eb;
    ea = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    eb = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  // Returns {HI, LO} = {remainder, quotient} with the zero-divisor and overflow cases pinned.
  function automatic logic [2*WIDTH-1:0] div_hilo(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic signed [WIDTH-1:0] sa, sb, q, r;
    if (b == '0) begin
      return {a, {WIDTH{1'b1}}};
    end else if (sgn && (a == MINV) && (b == {WIDTH{1'b1}})) begin
      return {{WIDTH{1'b0}}, a};
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
    end else begin
      return {a % b, a / b};
    end
  endfunction

  assign w_res = bus.MDU_Op[1] ? div_hilo(bus.MDU_A, bus.MDU_B, ~bus.MDU_Op[0])
                               : mul_hilo(bus.MDU_A, bus.MDU_B, ~bus.MDU_Op[0]);

  assign w_md_req = bus.MDU_Start && !bus.MDU_Op[2];
  assign w_mt_hi  = (r_state == S_IDLE) && bus.MDU_Start && (bus.MDU_Op == 3'b100);
  assign w_mt_lo  = (r_state == S_IDLE) && bus.MDU_Start && (bus.MDU_Op == 3'b101);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load     = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_md_req) begin
          w_load     = 1'b1;
          w_state_nx = S_RUN;
          w_cnt_nx   = bus.MDU_Op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      S_RUN: begin
        w_cnt_nx = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_commit   = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_commit;
      if (w_load) r_pend <= w_res;
      if (w_commit) begin
        {r_hi, r_lo} <= r_pend;
      end else if (w_mt_hi) begin
        r_hi <= bus.MDU_A;
      end else if (w_mt_lo) begin
        r_lo <= bus.MDU_A;
      end
    end
  end

  assign bus.MDU_Busy = (r_state == S_RUN);
  assign bus.MDU_Done = r_done;
  assign bus.MDU_HI   = r_hi;
  assign bus.MDU_LO   = r_lo;
endmodule
